scpu_mem_arbiter: RTL
=====================

# scpu_mem_arbiter

Two-requester arbiter that shares one single-port memory between the CPU's instruction-fetch port and its load/store data port. It serialises accesses over a req/ready memory handshake with variable latency, returns read data to the winning requester with a one-cycle ack, and aborts accesses whose memory does not answer within a bounded number of cycles. It sits between the CPU core and the unified program/data memory, replacing the separate ROM and data paths once the core moves beyond single-cycle operation.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; must be a multiple of 8
- `MAX_WAIT`, 15, cycles of `mem_ready` low tolerated before abort; range 1..255
- `ERR_RDATA`, 32'hDEADBEEF, read data returned on abort
- `clk`  in  1  clock; all state changes on the rising edge
- `reset`  in  1  asynchronous, active-low reset
- `if_req`  in  1  fetch request; held until `if_ack`
- `if_addr`  in  ADDR_W  fetch address
- `if_ack`  out  1  one-cycle completion pulse for fetch
- `if_rdata`  out  DATA_W  fetch data; valid while `if_ack`
- `d_req`  in  1  data request; held until `d_ack`
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_wmask`  in  DATA_W/8  byte enables for stores
- `d_ack`  out  1  one-cycle completion pulse for data
- `d_rdata`  out  DATA_W  load data; valid while `d_ack`
- `mem_req`  out  1  memory access valid
- `mem_we`, `mem_addr`, `mem_wdata`, `mem_wmask`  out  1/ADDR_W/DATA_W/DATA_W/8  registered copy of the granted request
- `mem_ready`  in  1  memory completes the access this cycle
- `mem_rdata`  in  DATA_W  read data; valid when `mem_ready`
- `err`  out  1  sticky abort flag

## Operation
- FSM states: IDLE, BUSY, ACK.
- IDLE: if any request, pick the winner, latch its fields into `mem_*`, set `mem_req`=1, clear the wait counter, record the winner in `owner` and go to BUSY.
- Fixed priority when both request: data over fetch.
- BUSY: hold `mem_*` stable.
  - On `mem_req && mem_ready`: capture `mem_rdata` into the owner's rdata register, drop `mem_req`, pulse the owner's ack and go to ACK.
  - Otherwise increment the wait counter. When the counter equals `MAX_WAIT`: drop `mem_req`, load `ERR_RDATA` as rdata, pulse ack, set `err`, go to ACK.
- ACK: the ack is high for exactly this cycle and requests are ignored. Next state is IDLE.
- Stores also receive an ack. Their rdata is `mem_rdata` as sampled and carries no meaning.
- Requesters must keep `*_req` and all request fields stable from assertion until they sample ack, then drop `*_req` in the ack cycle.
- The non-granted requester stays pending. No request is dropped.
- The wait counter is `$clog2(MAX_WAIT+1)` bits and saturates (no wrap).
- `err` is cleared only by reset.

## Timing
- Reset values: `mem_req`, `mem_we`, `if_ack`, `d_ack`, `err` = 0; `mem_addr`, `mem_wdata`, `mem_wmask`, `if_rdata`, `d_rdata` = 0; state IDLE; `owner` = fetch.
- All outputs are registered.
- Minimum latency, with `mem_ready` high on the first `mem_req` cycle:
  - `req` seen in cycle 0
  - `mem_req` in cycle 1
  - ack in cycle 2
  - IDLE in cycle 3
  - next grant visible in cycle 4.
- Throughput is therefore one access per 3 cycles at best.
- Abort: ack occurs `MAX_WAIT`+1 cycles after `mem_req` rises.
- `mem_ready` asserted while `mem_req`=0 is ignored.
- Reset asserted mid-access: all outputs clear immediately (asynchronous). The in-flight access is lost and is not acked.

## Configuration
- `SCPU_ARB_RR_EN` defined: round-robin between the two requesters. On a tie, the one not granted last wins, using `owner`. With no tie, the sole requester wins.
- Macro undefined: fixed data-over-fetch priority, and `owner` does not affect selection.

## Structure
- Package `scpu_arb_pkg` holds:
  - the state enum (IDLE/BUSY/ACK)
  - the owner encoding (OWN_IF/OWN_D)
  - the default `ERR_RDATA` constant.
- Sub-module `scpu_arb_pick`: purely combinational winner selection from `if_req`, `d_req` and `owner`. The `SCPU_ARB_RR_EN` switch lives only here.

## Test plan
- Fetch only, addr 0x10, memory ready the same cycle with rdata 0x00A00093 -> `mem_req` at cycle 1 with `mem_addr` 0x10, `if_ack` at cycle 2 with `if_rdata` 0x00A00093, `d_ack` never.
- Store with `d_addr` 0x200, `d_wdata` 0x12345678, `d_wmask` 4'b0011, memory ready after 3 wait cycles -> `mem_we`=1 and fields stable for 4 cycles, then one `d_ack` pulse.
- Both requesting continuously, 4 accesses: without the macro -> grants D,D,D,D while fetch starves only until `d_req` drops, then IF. With `SCPU_ARB_RR_EN` -> grants D,IF,D,IF.
- Memory never ready, `MAX_WAIT`=15 -> `mem_req` low after 16 cycles, ack with rdata 0xDEADBEEF, `err`=1 stays high through later successful accesses.
- Reset pulled low during BUSY -> `mem_req`, acks and `err` read 0 in the same cycle. After release, a pending `if_req` is granted normally from IDLE.
- `mem_ready` held high with no request -> no ack and no state change.

Source files
------------

// File: rtl/scpu_arb_pkg.sv
// ============================================================================
// Module   : scpu_arb_pkg
// Purpose  : Shared types and constants for the CPU memory arbiter:
//            FSM state encoding, owner (winning requester) encoding and the
//            default read data returned when an access is aborted.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package scpu_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ACK  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEADBEEF;

endpackage : scpu_arb_pkg

`default_nettype wire

// File: rtl/scpu_arb_pick.sv
// ============================================================================
// Module   : scpu_arb_pick
// Purpose  : Combinational winner selection between the fetch and data
//            requesters.
//            Macro SCPU_ARB_RR_EN: when defined, a tie goes to the requester
//            that did not win last time (taken from owner); when undefined,
//            data always beats fetch and owner does not affect the choice.
// Ports    : if_req  - fetch request pending
//            d_req   - data request pending
//            owner   - requester granted most recently
//            winner  - selected requester (meaningful only if a request exists)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module scpu_arb_pick
  import scpu_arb_pkg::*;
(
  input  logic   if_req,
  input  logic   d_req,
  input  owner_e owner,
  output owner_e winner
);

  always_comb begin
    // With no request the result is unused; keeping owner avoids a glitchy
    // default and ties the input into the logic in both builds.
    winner = owner;
`ifdef SCPU_ARB_RR_EN
    if (if_req && d_req) begin
      winner = (owner == OWN_D) ? OWN_IF : OWN_D;
    end else if (d_req) begin
      winner = OWN_D;
    end else if (if_req) begin
      winner = OWN_IF;
    end
`else
    if (d_req) begin
      winner = OWN_D;
    end else if (if_req) begin
      winner = OWN_IF;
    end
`endif
  end

endmodule : scpu_arb_pick

`default_nettype wire

// File: rtl/scpu_mem_arbiter.sv
// ============================================================================
// Module   : scpu_mem_arbiter
// Purpose  : Shares one single-port memory between the CPU fetch port and
//            the load/store port. One access is in flight at a time over a
//            req/ready handshake; the winner receives read data with a
//            one-cycle ack. Accesses the memory does not answer within
//            MAX_WAIT cycles are aborted with ERR_RDATA and a sticky err.
//            Arbitration policy selected by macro SCPU_ARB_RR_EN
//            (see scpu_arb_pick).
// Ports    : clk, reset (async, active-low)
//            if_req/if_addr -> if_ack/if_rdata      fetch requester
//            d_req/d_we/d_addr/d_wdata/d_wmask
//                           -> d_ack/d_rdata        data requester
//            mem_req/mem_we/mem_addr/mem_wdata/mem_wmask,
//            mem_ready/mem_rdata                    memory side
//            err                                    sticky abort flag
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module scpu_mem_arbiter
  import scpu_arb_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                MAX_WAIT  = 15,
  parameter logic [DATA_W-1:0] ERR_RDATA = DATA_W'(ERR_RDATA_DEFAULT)
) (
  input  logic                clk,
  input  logic                reset,
  // fetch port
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ack,
  output logic [DATA_W-1:0]   if_rdata,
  // data port
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wmask,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  // memory port
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   mem_rdata,
  // status
  output logic                err
);

  localparam int                CNT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_WAIT);

  arb_state_e          state_q,     state_d;
  owner_e              owner_q,     owner_d;
  logic [CNT_W-1:0]    wait_cnt_q,  wait_cnt_d;
  logic                mem_req_q,   mem_req_d;
  logic                mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W/8-1:0] mem_wmask_q, mem_wmask_d;
  logic                if_ack_q,    if_ack_d;
  logic                d_ack_q,     d_ack_d;
  logic [DATA_W-1:0]   if_rdata_q,  if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q,   d_rdata_d;
  logic                err_q,       err_d;

  owner_e              pick_winner;

  scpu_arb_pick u_pick (
    .if_req (if_req),
    .d_req  (d_req),
    .owner  (owner_q),
    .winner (pick_winner)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    wait_cnt_d  = wait_cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    err_d       = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (if_req || d_req) begin
          owner_d    = pick_winner;
          mem_req_d  = 1'b1;
          wait_cnt_d = '0;
          state_d    = ST_BUSY;
          if (pick_winner == OWN_D) begin
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            mem_wmask_d = d_wmask;
          end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            mem_wmask_d = '0;
          end
        end
      end

      ST_BUSY: begin
        if (mem_req_q && mem_ready) begin
          mem_req_d = 1'b0;
          state_d   = ST_ACK;
          if (owner_q == OWN_D) begin
            d_ack_d   = 1'b1;
            d_rdata_d = mem_rdata;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end else if (wait_cnt_q == CNT_MAX) begin
          // Timeout: counter holds at its limit, access is aborted.
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          state_d   = ST_ACK;
          if (owner_q == OWN_D) begin
            d_ack_d   = 1'b1;
            d_rdata_d = ERR_RDATA;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = ERR_RDATA;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end

      ST_ACK: begin
        // Requesters are dropping their req this cycle; do not re-grant.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      wait_cnt_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      err_q       <= err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wmask = mem_wmask_q;
  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign err       = err_q;

endmodule : scpu_mem_arbiter

`default_nettype wire
